// File: rtl/srm_pkg.sv
// Shared types and encodings for the Simple RISC Machine controller:
// FSM states, instruction class codes, ALU/writeback/memory command values.
package srm_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        S_IF1,
        S_IF2,
        S_UPDATE_PC,
        S_DECODE,
        S_WB_IMM,
        S_EXEC,
        S_EXEC_CMP,
        S_WB,
        S_ADDR,
        S_LD_ADDR,
        S_MEM_RD,
        S_LDR_WB,
        S_ST_DATA,
        S_ST_MEM,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_LDR  = 3'b011;
    localparam logic [2:0] OP_STR  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [1:0] SH_NONE = 2'b00;

endpackage

// File: rtl/srm_decoder.sv
// Combinational instruction decode: splits the IR into register/shift fields
// and classifies {opcode,op} into the instruction classes the FSM dispatches on.
module srm_decoder
    import srm_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  sh,
    output logic [1:0]  op,
    output logic        is_mov_imm,
    output logic        is_mov_reg,
    output logic        is_alu,
    output logic        is_mvn,
    output logic        is_cmp,
    output logic        is_ldr,
    output logic        is_str,
    output logic        is_halt,
    output logic        is_illegal
);

    logic [2:0] opcode;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    always_comb begin
        is_mov_imm = 1'b0;
        is_mov_reg = 1'b0;
        is_alu     = 1'b0;
        is_mvn     = 1'b0;
        is_cmp     = 1'b0;
        is_ldr     = 1'b0;
        is_str     = 1'b0;
        is_halt    = 1'b0;
        case (opcode)
            OP_MOV: begin
                is_mov_imm = (op == 2'b10);
                is_mov_reg = (op == 2'b00);
            end
            OP_ALU: begin
                is_alu = (op == ALU_ADD) || (op == ALU_AND);
                is_cmp = (op == ALU_SUB);
                is_mvn = (op == ALU_NOTB);
            end
            OP_LDR:  is_ldr  = (op == 2'b00);
            OP_STR:  is_str  = (op == 2'b00);
            OP_HALT: is_halt = (op == 2'b00);
            default: ;
        endcase
    end

    assign is_illegal = ~(is_mov_imm | is_mov_reg | is_alu | is_mvn | is_cmp |
                          is_ldr | is_str | is_halt);

endmodule

// File: rtl/srm_controller.sv
// Moore FSM sequencing the SRM datapath: fetch, decode, execute, one instruction at a time.
// Build option SRM_ILLEGAL_TRAP_EN: undefined encodings halt instead of running as a NOP.
module srm_controller
    import srm_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    output logic [2:0]  anum,
    output logic [2:0]  bnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        loadc,
    output logic        loads,
    output logic        load_ir,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        load_addr,
    output logic        addr_sel,
    output logic [1:0]  mem_cmd,
    output logic [7:0]  reset_pc_val,
    output logic        halted
);

    state_t     state_q;
    state_t     state_d;

    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic [1:0] sh;
    logic [1:0] op;
    logic       is_mov_imm;
    logic       is_mov_reg;
    logic       is_alu;
    logic       is_mvn;
    logic       is_cmp;
    logic       is_ldr;
    logic       is_str;
    logic       is_halt;
    logic       is_illegal;

    srm_decoder u_decoder (
        .ir         (ir),
        .rn         (rn),
        .rd         (rd),
        .rm         (rm),
        .sh         (sh),
        .op         (op),
        .is_mov_imm (is_mov_imm),
        .is_mov_reg (is_mov_reg),
        .is_alu     (is_alu),
        .is_mvn     (is_mvn),
        .is_cmp     (is_cmp),
        .is_ldr     (is_ldr),
        .is_str     (is_str),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    assign reset_pc_val = RESET_PC;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:     state_d = S_IF1;
            S_IF1:       state_d = S_IF2;
            S_IF2:       state_d = S_UPDATE_PC;
            S_UPDATE_PC: state_d = S_DECODE;
            S_DECODE: begin
                if (is_mov_imm) begin
                    state_d = S_WB_IMM;
                end else if (is_mov_reg || is_alu || is_mvn) begin
                    state_d = S_EXEC;
                end else if (is_cmp) begin
                    state_d = S_EXEC_CMP;
                end else if (is_ldr || is_str) begin
                    state_d = S_ADDR;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_illegal) begin
`ifdef SRM_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_IF1;
`endif
                end
            end
            S_WB_IMM:    state_d = S_IF1;
            S_EXEC:      state_d = S_WB;
            S_EXEC_CMP:  state_d = S_IF1;
            S_WB:        state_d = S_IF1;
            S_ADDR:      state_d = S_LD_ADDR;
            S_LD_ADDR:   state_d = is_str ? S_ST_DATA : S_MEM_RD;
            S_MEM_RD:    state_d = S_LDR_WB;
            S_LDR_WB:    state_d = S_IF1;
            S_ST_DATA:   state_d = S_ST_MEM;
            S_ST_MEM:    state_d = S_IF1;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_RESET;
        endcase
    end

    // Outputs are a pure function of the current state and the IR fields.
    always_comb begin
        anum      = 3'd0;
        bnum      = 3'd0;
        writenum  = 3'd0;
        write     = 1'b0;
        vsel      = VSEL_C;
        asel      = 1'b0;
        bsel      = 1'b0;
        shift     = SH_NONE;
        ALUop     = ALU_ADD;
        loadc     = 1'b0;
        loads     = 1'b0;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        mem_cmd   = MEM_NONE;
        halted    = 1'b0;
        case (state_q)
            S_RESET: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
            end
            S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
                load_ir  = 1'b1;
            end
            S_UPDATE_PC: load_pc = 1'b1;
            S_WB_IMM: begin
                writenum = rn;
                vsel     = VSEL_IMM8;
                write    = 1'b1;
            end
            S_EXEC: begin
                bnum  = rm;
                shift = sh;
                loadc = 1'b1;
                if (is_mov_reg) begin
                    asel  = 1'b1;
                    ALUop = ALU_ADD;
                end else if (is_mvn) begin
                    ALUop = ALU_NOTB;
                end else begin
                    anum  = rn;
                    ALUop = op;
                end
            end
            S_EXEC_CMP: begin
                anum  = rn;
                bnum  = rm;
                shift = sh;
                ALUop = ALU_SUB;
                loads = 1'b1;
            end
            S_WB: begin
                writenum = rd;
                vsel     = VSEL_C;
                write    = 1'b1;
            end
            S_ADDR: begin
                anum  = rn;
                bsel  = 1'b1;
                ALUop = ALU_ADD;
                loadc = 1'b1;
            end
            S_LD_ADDR: load_addr = 1'b1;
            S_MEM_RD:  mem_cmd = MEM_READ;
            S_LDR_WB: begin
                mem_cmd  = MEM_READ;
                writenum = rd;
                vsel     = VSEL_MDATA;
                write    = 1'b1;
            end
            S_ST_DATA: begin
                asel  = 1'b1;
                bnum  = rd;
                ALUop = ALU_ADD;
                loadc = 1'b1;
            end
            S_ST_MEM:  mem_cmd = MEM_WRITE;
            S_HALT:    halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_srm_controller.sv
// Self-checking bench for srm_controller: per-cycle instruction sequences from a
// behavioural model, a latency/pulse-count vector table, and halt/reset corners.
module tb_srm_controller;

    typedef struct packed {
        logic [2:0] anum;
        logic [2:0] bnum;
        logic [2:0] writenum;
        logic       write;
        logic [1:0] vsel;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       loadc;
        logic       loads;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       load_addr;
        logic       addr_sel;
        logic [1:0] mem_cmd;
        logic       halted;
    } outs_t;

    typedef struct {
        logic [15:0] ir;
        int          lat;
        int          nw;
        int          nl;
        int          nmw;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] ir = 16'h0000;

    logic [2:0]  anum, bnum, writenum;
    logic        write, asel, bsel, loadc, loads, load_ir, load_pc, reset_pc;
    logic        load_addr, addr_sel, halted;
    logic [1:0]  vsel, shift, aluop, mem_cmd;
    logic [7:0]  reset_pc_val;

    outs_t       act;
    outs_t       exp_q[$];
    vec_t        vecs[$];
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    srm_controller dut (
        .clk          (clk),
        .reset        (reset),
        .ir           (ir),
        .anum         (anum),
        .bnum         (bnum),
        .writenum     (writenum),
        .write        (write),
        .vsel         (vsel),
        .asel         (asel),
        .bsel         (bsel),
        .shift        (shift),
        .ALUop        (aluop),
        .loadc        (loadc),
        .loads        (loads),
        .load_ir      (load_ir),
        .load_pc      (load_pc),
        .reset_pc     (reset_pc),
        .load_addr    (load_addr),
        .addr_sel     (addr_sel),
        .mem_cmd      (mem_cmd),
        .reset_pc_val (reset_pc_val),
        .halted       (halted)
    );

    assign act = {anum, bnum, writenum, write, vsel, asel, bsel, shift, aluop,
                  loadc, loads, load_ir, load_pc, reset_pc, load_addr, addr_sel,
                  mem_cmd, halted};

    task automatic chk_o(input string name, input outs_t a, input outs_t e);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, a, e);
    endtask

    task automatic chk_i(input string name, input int a, input int e);
        n_total++;
        if (a == e) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, a, e);
    endtask

    function automatic outs_t rec_if1();
        outs_t o = '0;
        o.addr_sel = 1'b1;
        o.mem_cmd  = 2'b01;
        return o;
    endfunction

    function automatic outs_t rec_reset();
        outs_t o = '0;
        o.reset_pc = 1'b1;
        o.load_pc  = 1'b1;
        return o;
    endfunction

    function automatic outs_t rec_halt();
        outs_t o = '0;
        o.halted = 1'b1;
        return o;
    endfunction

    function automatic bit is_legal(input logic [4:0] cls);
        case (cls)
            5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111,
            5'b01100, 5'b10000, 5'b11100: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Expected output for every cycle from IF1 up to (not including) the next IF1.
    task automatic build_model(input logic [15:0] i);
        outs_t o;
        logic [2:0] rn, rd, rm;
        logic [1:0] sh;
        rn = i[10:8];
        rd = i[7:5];
        sh = i[4:3];
        rm = i[2:0];
        exp_q.delete();
        exp_q.push_back(rec_if1());
        o = rec_if1(); o.load_ir = 1'b1; exp_q.push_back(o);
        o = '0; o.load_pc = 1'b1; exp_q.push_back(o);
        o = '0; exp_q.push_back(o);
        case (i[15:11])
            5'b11010: begin
                o = '0; o.writenum = rn; o.vsel = 2'b10; o.write = 1'b1; exp_q.push_back(o);
            end
            5'b11000, 5'b10100, 5'b10110, 5'b10111: begin
                o = '0; o.bnum = rm; o.shift = sh; o.loadc = 1'b1;
                if (i[15:11] == 5'b11000) begin
                    o.asel = 1'b1; o.aluop = 2'b00;
                end else if (i[15:11] == 5'b10111) begin
                    o.aluop = 2'b11;
                end else begin
                    o.anum = rn; o.aluop = i[12:11];
                end
                exp_q.push_back(o);
                o = '0; o.writenum = rd; o.vsel = 2'b00; o.write = 1'b1; exp_q.push_back(o);
            end
            5'b10101: begin
                o = '0; o.anum = rn; o.bnum = rm; o.shift = sh; o.aluop = 2'b01; o.loads = 1'b1;
                exp_q.push_back(o);
            end
            5'b01100, 5'b10000: begin
                o = '0; o.anum = rn; o.bsel = 1'b1; o.loadc = 1'b1; exp_q.push_back(o);
                o = '0; o.load_addr = 1'b1; exp_q.push_back(o);
                if (i[15:11] == 5'b01100) begin
                    o = '0; o.mem_cmd = 2'b01; exp_q.push_back(o);
                    o = '0; o.mem_cmd = 2'b01; o.writenum = rd; o.vsel = 2'b11; o.write = 1'b1;
                    exp_q.push_back(o);
                end else begin
                    o = '0; o.asel = 1'b1; o.bnum = rd; o.loadc = 1'b1; exp_q.push_back(o);
                    o = '0; o.mem_cmd = 2'b10; exp_q.push_back(o);
                end
            end
            5'b11100: exp_q.push_back(rec_halt());
            default: begin
`ifdef SRM_ILLEGAL_TRAP_EN
                exp_q.push_back(rec_halt());
`endif
            end
        endcase
    endtask

    // Called with the DUT sitting in IF1, sampled 1 time unit after the edge.
    task automatic run_instr(input logic [15:0] i);
        ir = i;
        build_model(i);
        for (int k = 0; k < exp_q.size(); k++) begin
            chk_o($sformatf("instr_%h_cyc%0d", i, k), act, exp_q[k]);
            @(posedge clk); #1;
        end
        $display("instr %h: %0d cycles checked", i, exp_q.size());
    endtask

    task automatic measure(input logic [15:0] i, output int cyc, output int nw,
                           output int nl, output int nmw, output int ov);
        int p;
        ir = i; cyc = 0; nw = 0; nl = 0; nmw = 0; ov = 0;
        do begin
            p = 0;
            if (act.write) begin nw++; p++; end
            if (act.loads) begin nl++; p++; end
            if (act.mem_cmd == 2'b10) begin nmw++; p++; end
            if (p > 1) ov++;
            @(posedge clk); #1;
            cyc++;
        end while (act !== rec_if1() && cyc < 20);
    endtask

    // Assert reset mid-cycle, check it takes effect at once, release, land in IF1.
    task automatic do_reset(input string tag);
        #4 reset = 1'b1;
        #1 chk_o({tag, "_async"}, act, rec_reset());
        @(posedge clk); #1;
        chk_o({tag, "_held"}, act, rec_reset());
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc, nw, nl, nmw, ov;
        logic [4:0]  cls;
        logic [15:0] ri;

        vecs.push_back('{16'hD007, 5, 1, 0, 0});
        vecs.push_back('{16'hA148, 6, 1, 0, 0});
        vecs.push_back('{16'hB062, 6, 1, 0, 0});
        vecs.push_back('{16'hA902, 5, 0, 1, 0});
        vecs.push_back('{16'hC0A5, 6, 1, 0, 0});
        vecs.push_back('{16'hB800, 6, 1, 0, 0});
        vecs.push_back('{16'h6164, 8, 1, 0, 0});
        vecs.push_back('{16'h8164, 8, 0, 0, 1});
`ifndef SRM_ILLEGAL_TRAP_EN
        vecs.push_back('{16'h1800, 4, 0, 0, 0});
        vecs.push_back('{16'h6800, 4, 0, 0, 0});
        vecs.push_back('{16'hF000, 4, 0, 0, 0});
`endif

        #3 reset = 1'b1;
        #1 chk_o("reset_async", act, rec_reset());
        chk_i("reset_pc_val", int'(reset_pc_val), 0);
        @(posedge clk); #1;
        chk_o("reset_held", act, rec_reset());
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        run_instr(16'hD007);
        run_instr(16'hA148);
        run_instr(16'hA902);
        run_instr(16'h6164);
        run_instr(16'h8164);
        run_instr(16'hB800);

        foreach (vecs[v]) begin
            measure(vecs[v].ir, cyc, nw, nl, nmw, ov);
            chk_i($sformatf("lat_%h", vecs[v].ir), cyc, vecs[v].lat);
            chk_i($sformatf("write_pulses_%h", vecs[v].ir), nw, vecs[v].nw);
            chk_i($sformatf("loads_pulses_%h", vecs[v].ir), nl, vecs[v].nl);
            chk_i($sformatf("memwr_pulses_%h", vecs[v].ir), nmw, vecs[v].nmw);
            chk_i($sformatf("overlap_%h", vecs[v].ir), ov, 0);
            $display("vector %h: latency %0d", vecs[v].ir, cyc);
        end

        for (int n = 0; n < 250; n++) begin
            do begin
                cls = 5'($urandom_range(0, 31));
`ifdef SRM_ILLEGAL_TRAP_EN
            end while (cls == 5'b11100 || !is_legal(cls));
`else
            end while (cls == 5'b11100);
`endif
            ri = {cls, 11'($urandom)};
            run_instr(ri);
        end
        chk_o("if1_after_random", act, rec_if1());

        run_instr(16'hE000);
        for (int k = 0; k < 19; k++) begin
            chk_o($sformatf("halt_hold_%0d", k), act, rec_halt());
            @(posedge clk); #1;
        end
        do_reset("halt_reset");

        run_instr(16'h1800);
`ifdef SRM_ILLEGAL_TRAP_EN
        chk_o("illegal_halt_hold", act, rec_halt());
        do_reset("illegal_reset");
`endif
        chk_o("if1_after_illegal", act, rec_if1());

        ir = 16'h6164;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_reset("ldr_abort");
        run_instr(16'hD007);
        chk_o("final_if1", act, rec_if1());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
